// File: rtl/dt_peak_scan.sv
// dt_peak_scan
// ------------
// Peak scanner for the distance-transform result map. After the DT block
// finishes, a start pulse makes this block sweep the 128x128 distance map in
// raster order through the shared result-RAM read port. It reports the
// largest distance, the first raster position holding it, and the number of
// non-zero (foreground) pixels.
//
// Optional build macro: DT_PEAK_SUM_EN adds the dist_sum output, which holds
// the unsigned sum of every distance in the map.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     one-cycle pulse; begins a scan when idle or finished
//   busy      high while a scan is in progress
//   done      high once results are valid; held until the next accepted start
//   res_rd    result-RAM read enable
//   res_addr  result-RAM read address (row*128 + col)
//   res_di    result-RAM read data, valid RD_LAT cycles after its address
//   max_val   largest distance found
//   max_row   row of the first occurrence of max_val
//   max_col   column of the first occurrence of max_val
//   fg_cnt    number of non-zero pixels
//   dist_sum  sum of all distances (only with DT_PEAK_SUM_EN)
module dt_peak_scan #(
  parameter int IMG_LOG2 = 7,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  res_rd,
  output logic [2*IMG_LOG2-1:0] res_addr,
  input  logic [DATA_W-1:0]     res_di,
  output logic [DATA_W-1:0]     max_val,
  output logic [IMG_LOG2-1:0]   max_row,
  output logic [IMG_LOG2-1:0]   max_col,
  output logic [2*IMG_LOG2:0]   fg_cnt
`ifdef DT_PEAK_SUM_EN
  ,
  output logic [2*IMG_LOG2+DATA_W-1:0] dist_sum
`endif
);

  localparam int AW    = 2 * IMG_LOG2;
  localparam int CW    = AW + 1;
  localparam int SUM_W = AW + DATA_W;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   res_rd_q, res_rd_d;
  logic [AW-1:0]          res_addr_q, res_addr_d;
  logic [DATA_W-1:0]      max_val_q, max_val_d;
  logic [IMG_LOG2-1:0]    max_row_q, max_row_d;
  logic [IMG_LOG2-1:0]    max_col_q, max_col_d;
  logic [CW-1:0]          fg_cnt_q, fg_cnt_d;
  // Tag pipeline: each stage carries {valid, address} of an outstanding read,
  // so the last stage lines up with the data returning on res_di.
  logic [RD_LAT-1:0]          pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][AW-1:0]  pipe_addr_q, pipe_addr_d;
  logic [AW-1:0]              tail_addr;
`ifdef DT_PEAK_SUM_EN
  logic [SUM_W-1:0]       sum_q, sum_d;
`endif

  assign tail_addr = pipe_addr_q[RD_LAT-1];

  // Next-state, address generation, tag pipeline and accumulator update.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    res_rd_d   = res_rd_q;
    res_addr_d = res_addr_q;
    max_val_d  = max_val_q;
    max_row_d  = max_row_q;
    max_col_d  = max_col_q;
    fg_cnt_d   = fg_cnt_q;
`ifdef DT_PEAK_SUM_EN
    sum_d      = sum_q;
`endif

    pipe_vld_d[0]  = res_rd_q;
    pipe_addr_d[0] = res_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    // Consume the sample whose tag has reached the last stage. Strict '>'
    // keeps the earliest raster position on ties.
    if (pipe_vld_q[RD_LAT-1]) begin
      if (res_di != {DATA_W{1'b0}}) begin
        fg_cnt_d = fg_cnt_q + CW'(1);
      end else begin
        fg_cnt_d = fg_cnt_q;
      end
      if (res_di > max_val_q) begin
        max_val_d = res_di;
        max_row_d = tail_addr[AW-1:IMG_LOG2];
        max_col_d = tail_addr[IMG_LOG2-1:0];
      end else begin
        max_val_d = max_val_q;
      end
`ifdef DT_PEAK_SUM_EN
      sum_d = sum_q + SUM_W'(res_di);
`endif
    end else begin
      fg_cnt_d = fg_cnt_q;
    end

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d    = READ;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          res_rd_d   = 1'b1;
          res_addr_d = {AW{1'b0}};
          max_val_d  = {DATA_W{1'b0}};
          max_row_d  = {IMG_LOG2{1'b0}};
          max_col_d  = {IMG_LOG2{1'b0}};
          fg_cnt_d   = {CW{1'b0}};
`ifdef DT_PEAK_SUM_EN
          sum_d      = {SUM_W{1'b0}};
`endif
        end else begin
          state_d = state_q;
        end
      end
      READ: begin
        if (res_addr_q == LAST_ADDR) begin
          state_d  = DRAIN;
          res_rd_d = 1'b0;
        end else begin
          res_addr_d = res_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        // Finish one cycle after the final sample has left the pipeline.
        if (pipe_vld_q == {RD_LAT{1'b0}}) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_rd_q    <= 1'b0;
      res_addr_q  <= {AW{1'b0}};
      max_val_q   <= {DATA_W{1'b0}};
      max_row_q   <= {IMG_LOG2{1'b0}};
      max_col_q   <= {IMG_LOG2{1'b0}};
      fg_cnt_q    <= {CW{1'b0}};
      pipe_vld_q  <= {RD_LAT{1'b0}};
      pipe_addr_q <= {(RD_LAT*AW){1'b0}};
`ifdef DT_PEAK_SUM_EN
      sum_q       <= {SUM_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_rd_q    <= res_rd_d;
      res_addr_q  <= res_addr_d;
      max_val_q   <= max_val_d;
      max_row_q   <= max_row_d;
      max_col_q   <= max_col_d;
      fg_cnt_q    <= fg_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
`ifdef DT_PEAK_SUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign max_val  = max_val_q;
  assign max_row  = max_row_q;
  assign max_col  = max_col_q;
  assign fg_cnt   = fg_cnt_q;
`ifdef DT_PEAK_SUM_EN
  assign dist_sum = sum_q;
`endif

endmodule
